// File: rtl/btn_pulse_conditioner.sv
// Push-button front end: per channel a two-flop synchronizer, a debounce FSM,
// and a registered level with one-cycle rise/fall pulses.
module btn_pulse_conditioner #(
    parameter int N_BTN    = 4,
    parameter int DB_COUNT = 8,
    parameter int CW       = 16
) (
    input  logic             clkin,
    input  logic             btnR,
    input  logic             ce,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_lvl,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    typedef enum logic [1:0] {
        LO,
        WAIT_HI,
        HI,
        WAIT_LO
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_b;
    state_t           state [N_BTN];
    logic [CW-1:0]    cnt   [N_BTN];

    // The WAIT states count ce-qualified agreeing samples; any reversal of the
    // synchronized input drops straight back to the settled state, regardless of ce.
    always_ff @(posedge clkin) begin
        if (btnR) begin
            sync_a   <= '0;
            sync_b   <= '0;
            btn_lvl  <= '0;
            btn_rise <= '0;
            btn_fall <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= LO;
                cnt[i]   <= '0;
            end
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
            for (int i = 0; i < N_BTN; i++) begin
                btn_rise[i] <= 1'b0;
                btn_fall[i] <= 1'b0;
                case (state[i])
                    LO: begin
                        if (sync_b[i]) begin
                            state[i] <= WAIT_HI;
                            cnt[i]   <= '0;
                        end
                    end
                    WAIT_HI: begin
                        if (!sync_b[i]) begin
                            state[i] <= LO;
                            cnt[i]   <= '0;
                        end else if (ce) begin
                            if (cnt[i] == CNT_LAST) begin
                                state[i]    <= HI;
                                cnt[i]      <= '0;
                                btn_lvl[i]  <= 1'b1;
                                btn_rise[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + CW'(1);
                            end
                        end
                    end
                    HI: begin
                        if (!sync_b[i]) begin
                            state[i] <= WAIT_LO;
                            cnt[i]   <= '0;
                        end
                    end
                    WAIT_LO: begin
                        if (sync_b[i]) begin
                            state[i] <= HI;
                            cnt[i]   <= '0;
                        end else if (ce) begin
                            if (cnt[i] == CNT_LAST) begin
                                state[i]    <= LO;
                                cnt[i]      <= '0;
                                btn_lvl[i]  <= 1'b0;
                                btn_fall[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state[i] <= LO;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Self-checking bench for btn_pulse_conditioner: directed and random stimulus
// compared against a sample-history model of the debounce rules.
module tb_btn_pulse_conditioner;

    localparam int N  = 4;
    localparam int DB = 8;

    logic         clkin = 1'b0;
    logic         btnR  = 1'b1;
    logic         ce    = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_lvl;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;

    int n_cmp = 0;
    int n_err = 0;

    // Model: accepted level plus the number of counted samples since the
    // synchronized input began to disagree with it (-1 while it agrees).
    logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    int           pend [N];

    btn_pulse_conditioner #(.N_BTN(N), .DB_COUNT(DB), .CW(16)) dut (
        .clkin   (clkin),
        .btnR    (btnR),
        .ce      (ce),
        .btn_in  (btn_in),
        .btn_lvl (btn_lvl),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    always #5 clkin = ~clkin;

    task automatic model_update(input logic rst, input logic c, input logic [N-1:0] b);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < N; i++) pend[i] = -1;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] == m_lvl[i]) pend[i] = -1;
                else if (pend[i] < 0) pend[i] = 0;
                else if (c) begin
                    pend[i] = pend[i] + 1;
                    if (pend[i] == DB) begin
                        m_lvl[i] = m_s2[i];
                        if (m_s2[i]) m_rise[i] = 1'b1;
                        else m_fall[i] = 1'b1;
                        pend[i] = -1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    // One clock edge: drive at the falling edge, update the model at the rising edge,
    // return at the next falling edge where outputs are sampled.
    task automatic cycle(input logic rst, input logic c, input logic [N-1:0] b);
        btnR = rst; ce = c; btn_in = b;
        @(posedge clkin);
        model_update(rst, c, b);
        @(negedge clkin);
    endtask

    task automatic test_reset;
        for (int e = 0; e < 5; e++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), N'($urandom));
            n_cmp++;
            if ({btn_lvl, btn_rise, btn_fall} !== 12'h000) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %b want 0", e, {btn_lvl, btn_rise, btn_fall});
            end
        end
    endtask

    task automatic test_clean_press;
        int rise_edge, rise_cnt, fall_edge, fall_cnt;
        rise_edge = -1; rise_cnt = 0; fall_edge = -1; fall_cnt = 0;
        for (int e = 0; e < 4; e++) cycle(1'b0, 1'b1, '0);
        for (int e = 1; e <= 60; e++) begin
            cycle(1'b0, 1'b1, 4'b0001);
            if (btn_rise[0]) begin rise_cnt++; if (rise_edge < 0) rise_edge = e; end
            n_cmp++;
            if ({btn_lvl, btn_rise, btn_fall} !== {m_lvl, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL press_model edge %0d: got %b want %b", e, {btn_lvl, btn_rise, btn_fall}, {m_lvl, m_rise, m_fall});
            end
        end
        n_cmp++;
        if (rise_edge !== DB + 3 || rise_cnt !== 1) begin
            n_err++;
            $display("FAIL press_rise_timing: got edge %0d count %0d want edge %0d count 1", rise_edge, rise_cnt, DB + 3);
        end
        n_cmp++;
        if (btn_lvl[0] !== 1'b1) begin
            n_err++;
            $display("FAIL press_level: got %b want 1", btn_lvl[0]);
        end
        for (int e = 1; e <= 30; e++) begin
            cycle(1'b0, 1'b1, 4'b0000);
            if (btn_fall[0]) begin fall_cnt++; if (fall_edge < 0) fall_edge = e; end
            n_cmp++;
            if ({btn_lvl, btn_rise, btn_fall} !== {m_lvl, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL release_model edge %0d: got %b want %b", e, {btn_lvl, btn_rise, btn_fall}, {m_lvl, m_rise, m_fall});
            end
        end
        n_cmp++;
        if (fall_edge !== DB + 3 || fall_cnt !== 1 || btn_lvl[0] !== 1'b0) begin
            n_err++;
            $display("FAIL release_fall_timing: got edge %0d count %0d lvl %b want edge %0d count 1 lvl 0", fall_edge, fall_cnt, btn_lvl[0], DB + 3);
        end
    endtask

    task automatic test_bounce;
        logic seen;
        logic b;
        seen = 1'b0;
        for (int e = 0; e < 32; e++) begin
            b = (e < 5) || (e >= 7 && e < 12);
            cycle(1'b0, 1'b1, {2'b00, b, 1'b0});
            if (btn_lvl[1] || btn_rise[1] || btn_fall[1]) seen = 1'b1;
            n_cmp++;
            if ({btn_lvl, btn_rise, btn_fall} !== {m_lvl, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL bounce_model cycle %0d: got %b want %b", e, {btn_lvl, btn_rise, btn_fall}, {m_lvl, m_rise, m_fall});
            end
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_quiet: got activity %b want 0", seen);
        end
    endtask

    task automatic test_repeated;
        int rises, falls;
        logic wide;
        rises = 0; falls = 0; wide = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int e = 0; e < 80; e++) begin
                cycle(1'b0, 1'b1, (e < 60) ? 4'b0001 : 4'b0000);
                if (btn_rise[0]) rises++;
                if (btn_fall[0]) falls++;
                if ((btn_rise[0] && m_rise[0] == 1'b0) || (btn_fall[0] && m_fall[0] == 1'b0)) wide = 1'b1;
                n_cmp++;
                if ({btn_lvl, btn_rise, btn_fall} !== {m_lvl, m_rise, m_fall}) begin
                    n_err++;
                    $display("FAIL repeat_model press %0d cycle %0d: got %b want %b", p, e, {btn_lvl, btn_rise, btn_fall}, {m_lvl, m_rise, m_fall});
                end
            end
        end
        n_cmp++;
        if (rises !== 3 || falls !== 3 || wide !== 1'b0) begin
            n_err++;
            $display("FAIL repeat_counts: got rises %0d falls %0d wide %b want 3 3 0", rises, falls, wide);
        end
    endtask

    task automatic test_ce_gating;
        int rise_edge;
        for (int run = 0; run < 2; run++) begin
            rise_edge = -1;
            for (int e = 1; e <= 60; e++) begin
                cycle(1'b0, (e % 4) == 0, (run == 1 && e == 13) ? 4'b0000 : 4'b0100);
                if (btn_rise[2] && rise_edge < 0) rise_edge = e;
                n_cmp++;
                if ({btn_lvl, btn_rise, btn_fall} !== {m_lvl, m_rise, m_fall}) begin
                    n_err++;
                    $display("FAIL ce_model run %0d edge %0d: got %b want %b", run, e, {btn_lvl, btn_rise, btn_fall}, {m_lvl, m_rise, m_fall});
                end
            end
            n_cmp++;
            if (rise_edge !== ((run == 0) ? 32 : 48)) begin
                n_err++;
                $display("FAIL ce_rise_edge run %0d: got %0d want %0d", run, rise_edge, (run == 0) ? 32 : 48);
            end
            for (int e = 0; e < 20; e++) cycle(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_reset_mid;
        int rise_edge;
        logic early;
        rise_edge = -1; early = 1'b0;
        for (int e = 0; e < 6; e++) cycle(1'b0, 1'b1, 4'b1000);
        for (int e = 0; e < 2; e++) begin
            cycle(1'b1, 1'b1, 4'b1000);
            if (btn_rise[3] || btn_lvl[3]) early = 1'b1;
        end
        for (int e = 1; e <= 20; e++) begin
            cycle(1'b0, 1'b1, 4'b1000);
            if (btn_rise[3] && rise_edge < 0) rise_edge = e;
            n_cmp++;
            if ({btn_lvl, btn_rise, btn_fall} !== {m_lvl, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL reset_mid_model edge %0d: got %b want %b", e, {btn_lvl, btn_rise, btn_fall}, {m_lvl, m_rise, m_fall});
            end
        end
        n_cmp++;
        if (early !== 1'b0 || rise_edge !== DB + 3) begin
            n_err++;
            $display("FAIL reset_mid_rise: got early %b edge %0d want early 0 edge %0d", early, rise_edge, DB + 3);
        end
        for (int e = 0; e < 20; e++) cycle(1'b0, 1'b1, '0);
    endtask

    task automatic test_simultaneous;
        int hits;
        logic partial;
        hits = 0; partial = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            cycle(1'b0, 1'b1, 4'b1111);
            if (btn_rise == 4'b1111) hits++;
            else if (btn_rise != 4'b0000) partial = 1'b1;
        end
        n_cmp++;
        if (hits !== 1 || partial !== 1'b0 || btn_lvl !== 4'b1111) begin
            n_err++;
            $display("FAIL simultaneous_rise: got hits %0d partial %b lvl %b want 1 0 1111", hits, partial, btn_lvl);
        end
        for (int e = 0; e < 20; e++) cycle(1'b0, 1'b1, '0);
    endtask

    task automatic test_random;
        logic [N-1:0] b;
        logic [N-1:0] flip;
        b = '0;
        for (int e = 0; e < 1500; e++) begin
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 9) == 0);
            b = b ^ flip;
            cycle(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0), b);
            n_cmp++;
            if ({btn_lvl, btn_rise, btn_fall} !== {m_lvl, m_rise, m_fall}) begin
                n_err++;
                $display("FAIL random_model cycle %0d: got %b want %b", e, {btn_lvl, btn_rise, btn_fall}, {m_lvl, m_rise, m_fall});
            end
        end
        for (int e = 0; e < 30; e++) cycle(1'b0, 1'b1, '0);
    endtask

    initial begin
        model_update(1'b1, 1'b1, '0);
        @(negedge clkin);
        test_reset;
        test_clean_press;
        test_bounce;
        test_repeated;
        test_ce_gating;
        test_reset_mid;
        test_simultaneous;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_pulse_conditioner.md
Name: btn_pulse_conditioner

Overview:
- Front-end conditioner for the Lab4 push-buttons, sitting directly upstream of the 16-bit up/down counter.
- Per button: synchronizes the raw input, debounces it, and produces a clean level plus single-cycle rise/fall pulses.
- btnU/btnD rise pulses drive counter increment/decrement; btnL rise drives load; the btnC level drives count-enable.
- Each button path is identical and independent.

Parameters:
- N_BTN, 4, number of independent button channels.
- DB_COUNT, 8, consecutive ce-qualified stable samples required to accept a new level. Must be >= 1. Hardware builds override it larger.
- CW, 16, width of each per-channel debounce counter. Must satisfy 2^CW > DB_COUNT.

Ports:
- clkin  input  1  system clock, 100 MHz; all state on rising edge.
- btnR  input  1  reset, synchronous, active-high.
- ce  input  1  sample enable (e.g. digsel/qsec tick). Tie 1 to sample every cycle.
- btn_in  input  N_BTN  raw asynchronous button inputs.
- btn_lvl  output  N_BTN  debounced level.
- btn_rise  output  N_BTN  one-cycle pulse on an accepted 0->1 transition.
- btn_fall  output  N_BTN  one-cycle pulse on an accepted 1->0 transition.

Behaviour:
- Reset (btnR=1 at a clock edge):
  - Both synchronizer flops, state, and counter are cleared: sync=0, state=LO, cnt=0.
  - btn_lvl, btn_rise, btn_fall are all 0.
  - Reset has priority over every other event. Applying it mid-debounce aborts the debounce with no pulse.
- Synchronizer: two-flop chain per channel. s = second flop. No combinational path from btn_in to any output.
- Per-channel FSM states: LO, WAIT_HI, HI, WAIT_LO.
  - LO: if s=1, go to WAIT_HI with cnt<=0.
  - WAIT_HI, s=0: go to LO with cnt<=0. No pulse (glitch rejected).
  - WAIT_HI, s=1 and ce=1: if cnt==DB_COUNT-1, go to HI with btn_rise<=1; else cnt<=cnt+1.
  - WAIT_HI, s=1 and ce=0: hold state and cnt.
  - HI, WAIT_LO: mirror images of LO and WAIT_HI with s inverted. Exit from WAIT_LO emits btn_fall.
- btn_lvl=1 in states HI and WAIT_LO; 0 in LO and WAIT_HI. It is registered and changes on the same edge as the pulse.
- btn_rise/btn_fall are registered. Each is high for exactly one clock after its transition, then 0. They are never both high on one channel.
- Latency, with ce held 1, a clean step on btn_in before edge 1:
  - s=1 after edge 2.
  - WAIT_HI entered at edge 3.
  - btn_rise and btn_lvl go high at edge DB_COUNT+3 (edge 11 at default).
  - Release is symmetric: btn_fall at edge DB_COUNT+3 after release.
- Glitch rejection: a bounce in s lasting fewer than DB_COUNT ce-qualified cycles yields no pulse and no level change.
- Held input: a button held arbitrarily long yields exactly one rise, no repeats.
- Held through reset: btn_in=1 while btnR deasserts is treated as a fresh press. btn_rise fires at edge DB_COUNT+3 after the first edge with btnR=0.
- ce gating:
  - ce=0 freezes cnt only.
  - The abort on s reversal is not gated by ce.
  - A completion requires ce=1 on that edge.
- Channels never interact. Simultaneous presses on several channels produce simultaneous pulses when their timing is identical.
- Counter: cnt never exceeds DB_COUNT-1 and never wraps.

Test Plan:
- Reset/clean press: btnR=1 for 5 cycles, all outputs 0. Release reset; btn_in[0] 0->1 held 60 cycles (DB_COUNT=8, ce=1) -> btn_rise[0] high for exactly 1 cycle at edge 11 after the step, btn_lvl[0]=1 from that edge. Release -> btn_fall[0] single pulse 11 edges later, btn_lvl[0]=0.
- Bounce: btn_in[1] toggles high 5 cycles / low 2 / high 5 / low -> btn_rise[1], btn_fall[1], btn_lvl[1] stay 0 throughout.
- Repeated presses: btn_in[0] high 60 / low 20 cycles, three times -> exactly 3 btn_rise[0] and 3 btn_fall[0] pulses, each 1 cycle wide.
- ce gating: ce asserted 1 cycle in every 4, btn_in[2] held high -> btn_rise[2] appears after the 8th ce-high cycle in WAIT_HI. A 0 blip on s during a ce=0 cycle restarts the count.
- Reset mid-operation and held-through-reset: btnR pulsed while channel 3 is in WAIT_HI -> no pulse. With btn_in[3] still high, btn_rise[3] fires exactly at edge 11 after reset release.
- Simultaneous: btn_in[3:0]=4'b1111 applied on one edge -> btn_rise=4'b1111 on a single cycle, then 4'b0000.
